snn_layer_sequencer: RTL and testbench
======================================

# snn_layer_sequencer

Timestep sequencer for one fully-parallel spiking layer built from MAC + NCHU neuron slices. It clears neuron state at the start of each frame and accepts one input spike vector per timestep. For each timestep it drives the shared pixel bus, issues the `pulse` strobe and samples the layer's spike vector. After `T_STEPS` timesteps it reports the winning neuron by spike count over a ready/valid handshake. It sits between the input spike encoder and the classification readout.

## Interface
Parameters:
- `N_INPUTS`, 5: width of the input spike vector, which equals the pixel fan-in of every neuron.
- `N_NEURONS`, 10: number of neuron slices in the layer.
- `T_STEPS`, 16: timesteps per frame.
- `CNT_W`, 5: per-neuron spike-counter width.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin a frame; sampled only in IDLE.
- `busy`  out  1: high in every state except IDLE.
- `px_in`  in  N_INPUTS: input spike vector for one timestep.
- `px_valid`  in  1: `px_in` valid.
- `px_ready`  out  1: sequencer accepts `px_in`.
- `pixels_out`  out  N_INPUTS: held pixel vector driven to all neurons.
- `pulse`  out  1: one-cycle neuron integrate/fire strobe.
- `nrn_reset`  out  1: one-cycle neuron state clear.
- `spk_in`  in  N_NEURONS: registered spike outputs of the neurons.
- `class_out`  out  $clog2(N_NEURONS): index of the winning neuron.
- `class_count`  out  CNT_W: spike count of the winner.
- `class_valid`  out  1: result valid.
- `class_ready`  in  1: consumer accepts the result.

## Operation
FSM states and transitions:
- IDLE: if `start`, go to CLR. Timestep counter `t` and all spike counters are cleared on this transition.
- CLR: `nrn_reset`=1 for this cycle only. Go to WAIT_IN.
- WAIT_IN: `px_ready`=1. On `px_valid`&`px_ready`, register `px_in` into `pixels_out` and go to FIRE. Otherwise stay.
- FIRE: `pulse`=1. Go to SETTLE.
- SETTLE: single wait cycle covering the neuron output register. Go to SAMPLE.
- SAMPLE: for each neuron `i`, `cnt[i] += spk_in[i]`, saturating at 2^CNT_W−1.
  - If `t`==T_STEPS−1, go to ARGMAX.
  - Otherwise `t`++ and go to WAIT_IN.
- ARGMAX: sequential scan, one neuron per cycle, N_NEURONS cycles. Strict greater-than compare, so a tie goes to the lowest index. Go to DONE.
- DONE: `class_valid`=1, with `class_out`/`class_count` stable. On `class_ready`, go to IDLE.

General rules:
- `start` is ignored outside IDLE.
- `px_valid` is ignored outside WAIT_IN.
- `spk_in` is ignored outside SAMPLE.
- `pixels_out` holds its last accepted value, including across frames. It resets to 0.
- An all-zero spike history gives `class_out`=0, `class_count`=0.

## Timing
- Reset values: `busy`, `px_ready`, `pulse`, `nrn_reset`, `class_valid` = 0; `pixels_out`, `class_out`, `class_count` = 0. State is IDLE and all counters are 0.
- `reset` asserted in any state, including mid-frame and in DONE: on the next edge, return to IDLE with all outputs at reset values. No partial result is reported.
- `start` at edge k: `nrn_reset` is high in cycle k+1 and `px_ready` is high from cycle k+2.
- Handshake at edge h:
  - `pixels_out` is updated and `pulse` is high in cycle h+1.
  - `spk_in` is sampled at edge h+3.
  - `px_ready` is high again from cycle h+4.
  - Minimum is 4 cycles per timestep.
- Frame latency with `px_valid` held high: from the `start` edge to `class_valid` rising is 1+1+4·T_STEPS+N_NEURONS cycles, which is 76 at the defaults.
- `class_valid`&`class_ready` in the same cycle: the sequencer is in IDLE next cycle. A new `start` is accepted at the earliest one cycle later.

## Structure
- Shared package `snn_pkg`:
  - State enum `seq_state_t` (IDLE, CLR, WAIT_IN, FIRE, SETTLE, SAMPLE, ARGMAX, DONE).
  - Default constants for N_INPUTS, N_NEURONS, T_STEPS, CNT_W.
- One natural sub-module, `spike_counter_bank`:
  - Holds N saturating CNT_W counters with clear, increment-enable and a read mux for the argmax scan.
  - FSM, handshakes and argmax registers live in the top level.

## Test plan
- Reset mid-frame: assert `reset` while in SETTLE at t=3 → next cycle `busy`=0, `pulse`=0, `pixels_out`=0. A following frame starts cleanly.
- Single-winner frame:
  - Stimulus: `start`, `px_valid` held high, a neuron model in which neuron 7 spikes every timestep and the others never.
  - Required: `nrn_reset` pulses once, exactly 16 `pulse` strobes, and `class_valid` at cycle 76 with `class_out`=7, `class_count`=16.
- Saturation: CNT_W=3, neuron 2 spikes all 16 timesteps → `class_count`=7, `class_out`=2.
- Tie-break: neurons 4 and 9 both spike 5 times, the others 0 → `class_out`=4, `class_count`=5.
- Handshake stalls: `px_valid` low for 3 cycles before each timestep → each `pulse` occurs exactly 1 cycle after its handshake. `pixels_out` is stable from the handshake until the next handshake. `start` pulsed mid-frame has no effect.
- Output backpressure: hold `class_ready`=0 for 10 cycles → `class_valid`, `class_out`, `class_count` stay stable. Raising `class_ready` for one cycle gives `busy`=0 next cycle.

Source files
------------

// File: rtl/snn_layer_sequencer_pkg.sv
// Shared types and default sizing for the spiking-layer timestep sequencer.
package snn_pkg;

  localparam int DEF_N_INPUTS  = 5;
  localparam int DEF_N_NEURONS = 10;
  localparam int DEF_T_STEPS   = 16;
  localparam int DEF_CNT_W     = 5;

  // Sequencer control states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR     = 3'd1,
    WAIT_IN = 3'd2,
    FIRE    = 3'd3,
    SETTLE  = 3'd4,
    SAMPLE  = 3'd5,
    ARGMAX  = 3'd6,
    DONE    = 3'd7
  } seq_state_t;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snn_layer_sequencer_if.sv
// Pixel-input and classification-result handshakes of the layer sequencer.
// master = environment (encoder + readout), slave = sequencer.
interface snn_layer_sequencer_if #(
  parameter int N_INPUTS  = snn_pkg::DEF_N_INPUTS,
  parameter int N_NEURONS = snn_pkg::DEF_N_NEURONS,
  parameter int CNT_W     = snn_pkg::DEF_CNT_W
);
  localparam int IDX_W = snn_pkg::idx_width(N_NEURONS);

  logic [N_INPUTS-1:0] px_in;
  logic                px_valid;
  logic                px_ready;
  logic [IDX_W-1:0]    class_out;
  logic [CNT_W-1:0]    class_count;
  logic                class_valid;
  logic                class_ready;

  modport master (
    output px_in, px_valid, class_ready,
    input  px_ready, class_out, class_count, class_valid
  );

  modport slave (
    input  px_in, px_valid, class_ready,
    output px_ready, class_out, class_count, class_valid
  );

endinterface

// File: rtl/snn_layer_sequencer_counter_bank.sv
// Bank of saturating per-neuron spike counters with a read port used by the
// sequential argmax scan.
module spike_counter_bank
  import snn_pkg::*;
#(
  parameter int N     = DEF_N_NEURONS,
  parameter int CNT_W = DEF_CNT_W,
  parameter int IDX_W = idx_width(DEF_N_NEURONS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [N-1:0]     spk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_data
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_r [N];

  // Add one when enabled, holding at the top value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != CNT_MAX)) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  // Clear all counters at frame start, otherwise add this timestep's spikes.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= '0;
      end
    end else if (inc) begin
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= sat_inc(cnt_r[i], spk[i]);
      end
    end
  end

  // Read mux for the scan; indices past the last neuron read as zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < N) begin
      rd_data = cnt_r[rd_idx];
    end else begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/snn_layer_sequencer.sv
// Timestep sequencer for one spiking layer: clears the neurons, feeds one
// input spike vector per timestep, strobes integrate/fire, accumulates spike
// counts and reports the most active neuron over a ready/valid handshake.
module snn_layer_sequencer
  import snn_pkg::*;
#(
  parameter int N_INPUTS  = DEF_N_INPUTS,
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int T_STEPS   = DEF_T_STEPS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic [N_INPUTS-1:0]  pixels_out,
  output logic                 pulse,
  output logic                 nrn_reset,
  input  logic [N_NEURONS-1:0] spk_in,
  snn_layer_sequencer_if.slave bus
);

  localparam int IDX_W = idx_width(N_NEURONS);
  localparam int T_W   = idx_width(T_STEPS);
  localparam logic [T_W-1:0]   T_LAST   = T_W'(T_STEPS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);

  seq_state_t       state_r;
  logic [T_W-1:0]   t_r;
  logic [IDX_W-1:0] scan_idx_r;
  logic [IDX_W-1:0] best_idx_r;
  logic [CNT_W-1:0] best_cnt_r;

  logic             cnt_clr_s;
  logic             cnt_inc_s;
  logic [CNT_W-1:0] rd_cnt_s;
  logic [IDX_W-1:0] nxt_idx_s;
  logic [CNT_W-1:0] nxt_cnt_s;

  // Counter bank control: clear on frame start, accumulate only in SAMPLE.
  always_comb begin
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    case (state_r)
      IDLE:    cnt_clr_s = start;
      SAMPLE:  cnt_inc_s = 1'b1;
      default: begin
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
      end
    endcase
  end

  spike_counter_bank #(
    .N     (N_NEURONS),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr_s),
    .inc     (cnt_inc_s),
    .spk     (spk_in),
    .rd_idx  (scan_idx_r),
    .rd_data (rd_cnt_s)
  );

  // Running argmax: strict greater-than keeps the lowest index on ties.
  always_comb begin
    if (rd_cnt_s > best_cnt_r) begin
      nxt_idx_s = scan_idx_r;
      nxt_cnt_s = rd_cnt_s;
    end else begin
      nxt_idx_s = best_idx_r;
      nxt_cnt_s = best_cnt_r;
    end
  end

  // Frame sequencing FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      t_r             <= '0;
      scan_idx_r      <= '0;
      best_idx_r      <= '0;
      best_cnt_r      <= '0;
      busy            <= 1'b0;
      pixels_out      <= '0;
      pulse           <= 1'b0;
      nrn_reset       <= 1'b0;
      bus.px_ready    <= 1'b0;
      bus.class_out   <= '0;
      bus.class_count <= '0;
      bus.class_valid <= 1'b0;
    end else begin
      pulse     <= 1'b0;
      nrn_reset <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= CLR;
            t_r       <= '0;
            busy      <= 1'b1;
            nrn_reset <= 1'b1;
          end
        end
        CLR: begin
          state_r      <= WAIT_IN;
          bus.px_ready <= 1'b1;
        end
        WAIT_IN: begin
          if (bus.px_valid && bus.px_ready) begin
            pixels_out   <= bus.px_in;
            bus.px_ready <= 1'b0;
            pulse        <= 1'b1;
            state_r      <= FIRE;
          end
        end
        FIRE: begin
          state_r <= SETTLE;
        end
        SETTLE: begin
          state_r <= SAMPLE;
        end
        SAMPLE: begin
          if (t_r == T_LAST) begin
            state_r    <= ARGMAX;
            scan_idx_r <= '0;
            best_idx_r <= '0;
            best_cnt_r <= '0;
          end else begin
            t_r          <= t_r + T_W'(1);
            state_r      <= WAIT_IN;
            bus.px_ready <= 1'b1;
          end
        end
        ARGMAX: begin
          best_idx_r <= nxt_idx_s;
          best_cnt_r <= nxt_cnt_s;
          if (scan_idx_r == IDX_LAST) begin
            state_r         <= DONE;
            bus.class_out   <= nxt_idx_s;
            bus.class_count <= nxt_cnt_s;
            bus.class_valid <= 1'b1;
          end else begin
            scan_idx_r <= scan_idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.class_ready) begin
            state_r         <= IDLE;
            busy            <= 1'b0;
            bus.class_valid <= 1'b0;
          end
        end
        default: begin
          state_r         <= IDLE;
          busy            <= 1'b0;
          bus.px_ready    <= 1'b0;
          bus.class_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Scoreboard bench: two sequencers (CNT_W=5 and CNT_W=3) run in lockstep on
// identical stimulus; a bench-side neuron model replays a per-frame spike
// pattern, and a monitor checks results, timing and handshake rules.
module tb_snn_layer_sequencer;
  import snn_pkg::*;

  localparam int NI   = 5;
  localparam int NN   = 10;
  localparam int T    = 16;
  localparam int IW   = 4;
  localparam int SATA = 31;
  localparam int SATB = 7;

  typedef struct {
    int cls_a;
    int cnt_a;
    int cls_b;
    int cnt_b;
    bit fast;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, px_valid, class_ready;
  logic [NI-1:0] px_in;
  logic [NN-1:0] spk_in;
  logic [NN-1:0] pat [T];

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  snn_layer_sequencer_if #(.N_INPUTS(NI), .N_NEURONS(NN), .CNT_W(5)) bus_a ();
  snn_layer_sequencer_if #(.N_INPUTS(NI), .N_NEURONS(NN), .CNT_W(3)) bus_b ();

  assign bus_a.px_in = px_in;   assign bus_b.px_in = px_in;
  assign bus_a.px_valid = px_valid;   assign bus_b.px_valid = px_valid;
  assign bus_a.class_ready = class_ready; assign bus_b.class_ready = class_ready;

  logic          bsy [2];
  logic          pls [2];
  logic          nrs [2];
  logic [NI-1:0] pix [2];

  snn_layer_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN), .T_STEPS(T), .CNT_W(5)) dut_a (
    .clk(clk), .reset(reset), .start(start), .busy(bsy[0]), .pixels_out(pix[0]),
    .pulse(pls[0]), .nrn_reset(nrs[0]), .spk_in(spk_in), .bus(bus_a.slave));

  snn_layer_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN), .T_STEPS(T), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .busy(bsy[1]), .pixels_out(pix[1]),
    .pulse(pls[1]), .nrn_reset(nrs[1]), .spk_in(spk_in), .bus(bus_b.slave));

  logic          prdy [2];
  logic          cval [2];
  logic [IW-1:0] cls  [2];
  logic [4:0]    ccnt [2];
  assign prdy[0] = bus_a.px_ready;    assign prdy[1] = bus_b.px_ready;
  assign cval[0] = bus_a.class_valid; assign cval[1] = bus_b.class_valid;
  assign cls[0]  = bus_a.class_out;   assign cls[1]  = bus_b.class_out;
  assign ccnt[0] = bus_a.class_count; assign ccnt[1] = {2'b00, bus_b.class_count};

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: count spikes per neuron over the frame, clip, pick the first maximum.
  task automatic model(input int sat, output int cls_o, output int cnt_o);
    int c [NN];
    for (int i = 0; i < NN; i++) c[i] = 0;
    for (int t = 0; t < T; t++)
      for (int i = 0; i < NN; i++)
        if (pat[t][i]) c[i]++;
    cls_o = 0;
    cnt_o = 0;
    for (int i = 0; i < NN; i++) begin
      if (c[i] > sat) c[i] = sat;
      if (c[i] > cnt_o) begin
        cls_o = i;
        cnt_o = c[i];
      end
    end
  endtask

  // Neuron model: registered spikes appear after each pulse and stay for the
  // sampling window; outside it the lines carry random garbage.
  initial begin
    int tidx = 0;
    int d = 3;
    spk_in = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        tidx = 0;
        d = 3;
      end else if (nrs[0]) begin
        tidx = 0;
      end
      if (pls[0]) begin
        spk_in = pat[(tidx < T) ? tidx : T - 1];
        tidx++;
        d = 0;
      end else begin
        d++;
        if (d >= 3) spk_in = NN'($urandom);
      end
    end
  end

  // Monitor: reset values, pulse/pixel timing, latency, result scoreboard,
  // backpressure stability and return to idle.
  initial begin
    bit            rst_pend = 1'b0, hs_pend = 1'b0, st_pend = 1'b0;
    bit            frame_on = 1'b0, idle_pend = 1'b0, prev_r = 1'b0;
    bit            prev_v [2];
    logic [IW-1:0] prev_cls [2];
    logic [4:0]    prev_cnt [2];
    logic [NI-1:0] pend_px = '0, acc_px = '0;
    int            cyc = 0, pulse_cnt = 0, nrn_cnt = 0;
    exp_t          e;
    prev_v[0] = 1'b0; prev_v[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_pend) begin
        for (int k = 0; k < 2; k++) begin
          check("rst busy", bsy[k], 0);
          check("rst pulse", pls[k], 0);
          check("rst pixels_out", pix[k], 0);
          check("rst px_ready", prdy[k], 0);
          check("rst nrn_reset", nrs[k], 0);
          check("rst class_valid", cval[k], 0);
          check("rst class_out", cls[k], 0);
          check("rst class_count", ccnt[k], 0);
          prev_v[k] = 1'b0;
        end
        acc_px = '0; frame_on = 1'b0; idle_pend = 1'b0;
        pulse_cnt = 0; nrn_cnt = 0;
      end else begin
        if (hs_pend) acc_px = pend_px;
        for (int k = 0; k < 2; k++) begin
          check("pixels_out hold", pix[k], acc_px);
          if (pls[k] || hs_pend) check("pulse after handshake", pls[k], hs_pend);
        end
        if (pls[0]) pulse_cnt++;
        if (nrs[0]) nrn_cnt++;
        if (idle_pend) begin
          for (int k = 0; k < 2; k++) begin
            check("idle busy", bsy[k], 0);
            check("idle class_valid", cval[k], 0);
          end
          idle_pend = 1'b0;
        end
        if (st_pend) begin
          frame_on = 1'b1;
          cyc = 0;
        end
        if (frame_on) begin
          cyc++;
          if (cyc == 1) for (int k = 0; k < 2; k++) check("nrn_reset at k+1", nrs[k], 1);
          if (cyc == 2) for (int k = 0; k < 2; k++) check("px_ready at k+2", prdy[k], 1);
        end
        for (int k = 0; k < 2; k++) begin
          if (prev_v[k] && !prev_r) begin
            check("stall class_valid", cval[k], 1);
            check("stall class_out", cls[k], prev_cls[k]);
            check("stall class_count", ccnt[k], prev_cnt[k]);
          end
        end
        if (cval[0] && !prev_v[0] && frame_on && sb.size() > 0 && sb[0].fast)
          check("frame latency", cyc, 1 + 1 + 4 * T + NN);
        if (cval[0] && class_ready) begin
          check("result expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("class_out a", cls[0], e.cls_a);
            check("class_count a", ccnt[0], e.cnt_a);
            check("class_out b", cls[1], e.cls_b);
            check("class_count b", ccnt[1], e.cnt_b);
            check("class_valid b", cval[1], 1);
            check("pulse count", pulse_cnt, T);
            check("nrn_reset count", nrn_cnt, 1);
          end
          pulse_cnt = 0; nrn_cnt = 0;
          idle_pend = 1'b1; frame_on = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
          prev_v[k] = cval[k];
          prev_cls[k] = cls[k];
          prev_cnt[k] = ccnt[k];
        end
        prev_r = class_ready;
      end
      rst_pend = reset;
      hs_pend = px_valid && prdy[0] && !reset;
      pend_px = px_in;
      st_pend = start && !bsy[0] && !reset;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame. stall<0 picks 0..3 idle cycles per timestep at random.
  task automatic run_frame(input int stall, input bit mid_start, input int bp, input bit abort);
    exp_t e;
    int   s, w;
    bit   hs;
    if (!abort) begin
      model(SATA, e.cls_a, e.cnt_a);
      model(SATB, e.cls_b, e.cnt_b);
      e.fast = (stall == 0) && (bp == 0) && !mid_start;
      sb.push_back(e);
    end
    class_ready = (bp == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < T; t++) begin
      s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      if (s > 0) begin
        px_valid = 1'b0;
        repeat (s) begin
          px_in = NI'($urandom);
          tick();
        end
      end
      px_in = NI'($urandom);
      px_valid = 1'b1;
      hs = 1'b0;
      w = 0;
      while (!hs && w < 40) begin
        hs = prdy[0];
        tick();
        w++;
      end
      check("px handshake", hs, 1);
      px_in = NI'($urandom);
      if (abort && t == 3) begin
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        px_valid = 1'b0;
        return;
      end
      if (mid_start && t == 8) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    px_valid = 1'b0;
    w = 0;
    while (!cval[0] && w < 200) begin
      tick();
      w++;
    end
    check("class_valid wait", cval[0], 1);
    if (bp > 0) begin
      repeat (bp) tick();
      class_ready = 1'b1;
      tick();
      class_ready = 1'b0;
    end else begin
      tick();
    end
    tick();
  endtask

  task automatic fill_rand();
    for (int t = 0; t < T; t++) pat[t] = NN'($urandom) & NN'($urandom);
  endtask

  task automatic fill_zero();
    for (int t = 0; t < T; t++) pat[t] = '0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; px_valid = 1'b0; class_ready = 1'b0; px_in = '0;
    fill_zero();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Neuron 7 fires every timestep.
    fill_zero();
    for (int t = 0; t < T; t++) pat[t][7] = 1'b1;
    run_frame(0, 1'b0, 0, 1'b0);

    // Neuron 2 fires every timestep; saturates in the 3-bit instance.
    fill_zero();
    for (int t = 0; t < T; t++) pat[t][2] = 1'b1;
    run_frame(0, 1'b0, 0, 1'b0);

    // Tie: neurons 4 and 9 each fire 5 times.
    fill_zero();
    for (int t = 0; t < 5; t++) pat[t][4] = 1'b1;
    for (int t = 3; t < 8; t++) pat[t][9] = 1'b1;
    run_frame(0, 1'b0, 0, 1'b0);

    // Reset in SETTLE of timestep 3, then a clean frame.
    fill_rand();
    run_frame(1, 1'b0, 0, 1'b1);
    fill_rand();
    run_frame(0, 1'b0, 0, 1'b0);

    // Input stalls with a stray start mid-frame.
    fill_rand();
    run_frame(3, 1'b1, 0, 1'b0);

    // Result backpressure.
    fill_rand();
    run_frame(0, 1'b0, 10, 1'b0);

    // No spikes at all.
    fill_zero();
    run_frame(0, 1'b0, 0, 1'b0);

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      fill_rand();
      run_frame(-1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1'b0);
    end

    check("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
